// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arbiter_pkg;
  localparam int AW_DEF  = 3;
  localparam int DW_DEF  = 8;
  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshake and RAM pin signals around the arbiter.
// slave  = arbiter side, master = requesters plus RAM side.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant; one-hot or zero output.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);
  // A lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters. One transaction in flight: IDLE (grant) -> ACCESS -> RESP.
// Optional grant counters enabled with RAM_ARBITER_STATS_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  ram_arbiter_if.slave       bus
`ifdef RAM_ARBITER_STATS_EN
  ,
  output logic [STATS_W-1:0] grant_cnt0,
  output logic [STATS_W-1:0] grant_cnt1
`endif
);
  state_t        r_state;
  state_t        w_state_next;
  logic          r_id;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_last_grant;
  logic [1:0]    w_grant;
  logic          w_accept;
  logic          w_sel;

  rr_arb2 u_rr_arb2 (
    .i_valid      (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Grant only counts in IDLE; w_sel picks which requester's command to latch.
  assign w_accept = (r_state == IDLE) && (w_grant != 2'b00);
  assign w_sel    = w_grant[1];

  // Address and data are held from the last command so dout stays stable in RESP.
  assign bus.ram_addr = r_addr;
  assign bus.ram_din  = r_wdata;

  // Next-state and handshake/response decode.
  always_comb begin
    w_state_next  = r_state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.rsp_rdata = '0;
    bus.ram_we    = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = w_grant;
        if (w_accept) w_state_next = ACCESS;
      end
      ACCESS: begin
        bus.ram_we   = r_we;
        w_state_next = RESP;
      end
      RESP: begin
        bus.rsp_valid = r_id ? 2'b10 : 2'b01;
        bus.rsp_rdata = r_we ? '0 : bus.ram_dout;
        w_state_next  = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register and command capture on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_id         <= w_sel;
        r_we         <= bus.req_we[w_sel];
        r_addr       <= w_sel ? bus.req_addr1  : bus.req_addr0;
        r_wdata      <= w_sel ? bus.req_wdata1 : bus.req_wdata0;
        r_last_grant <= w_sel;
      end
    end
  end

`ifdef RAM_ARBITER_STATS_EN
  logic [STATS_W-1:0] r_grant_cnt [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      // Saturating count of accepted commands for requester gi.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_grant_cnt[gi] <= '0;
        end else if (w_accept && w_grant[gi] && (r_grant_cnt[gi] != {STATS_W{1'b1}})) begin
          r_grant_cnt[gi] <= r_grant_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign grant_cnt0 = r_grant_cnt[0];
  assign grant_cnt1 = r_grant_cnt[1];
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 8x8 RAM.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter_if bus ();

`ifdef RAM_ARBITER_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1));
`else
  ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // Single-port synchronous RAM: write when we, otherwise read, 1-cycle latency.
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    else            bus.ram_dout <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input bit we, input logic [2:0] a, input logic [7:0] d);
    bus.req_valid[id] = 1'b1;
    bus.req_we[id]    = we;
    if (id == 0) begin bus.req_addr0 = a; bus.req_wdata0 = d; end
    else         begin bus.req_addr1 = a; bus.req_wdata1 = d; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction from a single requester; called and returns at a negedge.
  task automatic txn(input int id, input bit we, input logic [2:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd);
    logic [1:0] onehot;
    onehot = (id == 0) ? 2'b01 : 2'b10;
    drive(id, we, a, d);
    #1;
    chk("ready", bus.req_ready, onehot);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    chk("acc_we", bus.ram_we, we);
    chk("acc_addr", bus.ram_addr, a);
    if (we) chk("acc_din", bus.ram_din, d);
    chk("acc_rsp", bus.rsp_valid, 2'b00);
    @(negedge clk);
    chk("rsp_valid", bus.rsp_valid, onehot);
    chk("rsp_rdata", bus.rsp_rdata, we ? 8'h00 : exp_rd);
    chk("rsp_we", bus.ram_we, 1'b0);
    $display("txn id=%0d we=%0d addr=%0d wdata=%02h rdata=%02h", id, we, a, d, bus.rsp_rdata);
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_we     = 2'b00;
    bus.req_addr0  = '0;
    bus.req_addr1  = '0;
    bus.req_wdata0 = '0;
    bus.req_wdata1 = '0;
    @(negedge clk);
    do_reset();

    // Reset state.
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_rsp", bus.rsp_valid, 2'b00);
    chk("rst_rdata", bus.rsp_rdata, 8'h00);
    chk("rst_we", bus.ram_we, 1'b0);
    chk("rst_addr", bus.ram_addr, 3'd0);
    chk("rst_din", bus.ram_din, 8'h00);

    // Requester 0 write then read back.
    txn(0, 1'b1, 3'd3, 8'hA5, 8'h00);
    txn(0, 1'b0, 3'd3, 8'h00, 8'hA5);

    // Requester 1 alone writes address 7.
    chk("pre_we", bus.ram_we, 1'b0);
    txn(1, 1'b1, 3'd7, 8'h3C, 8'h00);

    // Both hold valid: strict alternation starting with requester 0 after reset.
    do_reset();
    drive(0, 1'b0, 3'd3, 8'h00);
    drive(1, 1'b0, 3'd7, 8'h00);
    for (int k = 0; k < 8; k++) begin
      logic [1:0] e;
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_ready", bus.req_ready, e);
      @(posedge clk);
      @(negedge clk);
      if (k == 6) bus.req_valid[0] = 1'b0;
      if (k == 7) bus.req_valid[1] = 1'b0;
      chk("rr_acc_ready", bus.req_ready, 2'b00);
      @(negedge clk);
      chk("rr_rsp", bus.rsp_valid, e);
      chk("rr_rdata", bus.rsp_rdata, (k % 2 == 0) ? 8'hA5 : 8'h3C);
      $display("txn rr k=%0d grant=%b rdata=%02h", k, e, bus.rsp_rdata);
      @(negedge clk);
    end

    // Fill all addresses with addr*17 and read back via alternating requesters.
    for (int a = 0; a < 8; a++) txn(a % 2, 1'b1, a[2:0], 8'(a * 17), 8'h00);
    for (int a = 0; a < 8; a++) txn((a + 1) % 2, 1'b0, a[2:0], 8'h00, 8'(a * 17));

    // Reset during the ACCESS cycle of a write: write lands, ack is dropped.
    drive(0, 1'b1, 3'd2, 8'hFF);
    #1;
    chk("rw_ready", bus.req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    chk("rw_we", bus.ram_we, 1'b1);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("rw_rsp0", bus.rsp_valid, 2'b00);
    chk("rw_we0", bus.ram_we, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_rsp1", bus.rsp_valid, 2'b00);
    $display("txn reset-during-write addr=2");
    txn(0, 1'b0, 3'd2, 8'h00, 8'hFF);

`ifdef RAM_ARBITER_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) txn(0, 1'b0, 3'd1, 8'h00, 8'd17);
    for (int i = 0; i < 3; i++) txn(1, 1'b0, 3'd1, 8'h00, 8'd17);
    chk("cnt0", grant_cnt0, 16'd5);
    chk("cnt1", grant_cnt1, 16'd3);
    dut.r_grant_cnt[0] = 16'hFFFE;
    for (int i = 0; i < 3; i++) txn(0, 1'b0, 3'd1, 8'h00, 8'd17);
    chk("cnt0_sat", grant_cnt0, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter that shares a single-port 8x8 synchronous RAM (1-cycle read latency, read-or-write per edge, write enable high) between two masters. Each requester issues a read or write through a valid/ready handshake and gets a one-cycle response pulse. The arbiter owns the RAM's `we`/`addr`/`din` pins and samples its `dout`. It sits directly in front of the RAM; nothing else may drive the RAM ports.

## Interface
- `AW`, default 3: RAM address width (8 locations).
- `DW`, default 8: RAM data width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  2  per-requester command valid; bit i is requester i.
- `req_ready`  out  2  per-requester accept; a command transfers on `valid & ready` at a rising edge.
- `req_we`  in  2  per-requester command type: 1 = write, 0 = read.
- `req_addr0`, `req_addr1`  in  AW  per-requester address.
- `req_wdata0`, `req_wdata1`  in  DW  per-requester write data.
- `rsp_valid`  out  2  one-cycle completion pulse to the owning requester.
- `rsp_rdata`  out  DW  read data, qualified by `rsp_valid`.
- `ram_we`  out  1  to RAM write enable.
- `ram_addr`  out  AW  to RAM address.
- `ram_din`  out  DW  to RAM write data.
- `ram_dout`  in  DW  from RAM read data.

## Operation
- States:
  - IDLE: `req_ready` may assert; a grant is made.
  - ACCESS: the registered command is driven on the RAM ports.
  - RESP: `rsp_valid` pulses.
- Transitions: IDLE→ACCESS on an accepted command, ACCESS→RESP always, RESP→IDLE always. Exactly one transaction is in flight at a time.
- Grant, evaluated in IDLE only:
  - One valid requester: it wins.
  - Both valid: the requester not granted last wins. `last_grant` resets to 1, so requester 0 wins the first tie.
  - `req_ready[i] = (state==IDLE) & grant[i]`; this is combinational from `req_valid` and state. At most one bit is high.
- On accept, register the requester id, `we`, `addr` and `wdata`; update `last_grant`.
- RAM port rules:
  - `ram_we` = 1 only in ACCESS and only for a write; 0 in all other cycles.
  - `ram_addr` and `ram_din` hold their last registered values outside ACCESS. The RAM reads every non-write edge, so holding the address keeps `dout` stable through RESP.
- Response, in RESP:
  - `rsp_valid[id]` = 1 and the other bit = 0.
  - `rsp_rdata` = `ram_dout` for a read, 0 for a write.
  - Writes get the same ack pulse as reads.
- Requesters must hold valid and their command stable until ready. Dropping valid before ready is legal and withdraws the request.

## Timing
- Accept at the edge ending cycle n. Cycle n+1 is ACCESS; the RAM writes or reads at the end of n+1. Cycle n+2 is RESP, with `rsp_valid` high for exactly that cycle.
- Throughput is one transaction per 3 cycles. The earliest next accept is in cycle n+3.
- Reset values: state = IDLE, `req_ready` = 00, `rsp_valid` = 00, `rsp_rdata` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0, `last_grant` = 1.
- Reset mid-operation: the next edge returns to IDLE and no response is issued.
  - Exception: if `rst` is high during an ACCESS cycle with `ram_we` = 1, the RAM samples that write on the same edge. The write lands; the ack is lost.
- A requester holding valid continuously while the other is also valid is granted on alternate transactions, never twice in a row.

## Configuration
- `RAM_ARBITER_STATS_EN` defined:
  - Adds outputs `grant_cnt0` and `grant_cnt1` (16 bits each).
  - Each counts accepted commands for its requester, saturates at 16'hFFFF, and resets to 0 synchronously.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

## Structure
- Package `ram_arbiter_pkg`:
  - state enum {IDLE, ACCESS, RESP};
  - default `AW`/`DW` constants;
  - the `STATS_W` = 16 constant.
- Sub-module `rr_arb2`: combinational 2-way round-robin grant from `req_valid` and `last_grant`, emitting a one-hot grant.
- The RAM is not instantiated inside the arbiter; the bench and top level connect it to the `ram_*` ports.

## Test plan
- After reset, requester 0 writes 8'hA5 to address 3, then reads address 3 → `rsp_valid` = 01 in cycle n+2 of each transaction; the read returns `rsp_rdata` = 8'hA5.
- Both requesters hold valid continuously, each doing 4 reads → grant order 0,1,0,1,0,1,0,1; each `rsp_valid` pulse goes to the matching bit.
- Requester 1 writes 8'h3C to address 7 while requester 0 is idle → `req_ready` = 10, `ram_we` high for exactly 1 cycle with `ram_addr` = 7 and `ram_din` = 8'h3C, then `rsp_valid` = 10 with `rsp_rdata` = 0.
- Write all 8 addresses with value addr*17, then read them back through alternating requesters → every read matches, covering addresses 0 and 7.
- Assert `rst` during ACCESS of a write of 8'hFF to address 2 → no `rsp_valid` pulse, state returns to IDLE, and a later read of address 2 returns 8'hFF.
- With `RAM_ARBITER_STATS_EN` defined: 5 grants to requester 0 and 3 to requester 1 → `grant_cnt0` = 5 and `grant_cnt1` = 3; preloading the counter to 16'hFFFE and issuing 3 grants gives 16'hFFFF.
